if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. Owns the PC, issues word fetches to instruction memory over a valid/ready request channel, and accepts single-beat responses. Presents `instruction_next` / `inst_address_next` to IF/ID. Handles hazard-unit stalls with a one-entry hold buffer and branch/jump redirects with in-flight response kill.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INST`, default 32'h0000_0000: instruction driven when no fetched word is available (bubble).
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-high. Asserted = 1; the name is kept for codebase consistency.
- `stall` in 1: hazard-unit stall, the same signal that holds IF/ID. When high, the presented instruction is not consumed.
- `redirect_valid` in 1: branch/jump resolved taken this cycle.
- `redirect_target` in 32: new fetch address.
- `imem_req_valid` out 1, `imem_req_ready` in 1, `imem_req_addr` out 32: fetch request channel.
- `imem_rsp_valid` in 1, `imem_rsp_data` in 32: response. Arrives ≥1 cycle after request acceptance, in order.
- `instruction_next` out 32, `inst_address_next` out 32: to IF/ID.
- `fetch_bubble` out 1: high when `instruction_next` is `NOP_INST` because no valid word is available.
- `fetch_misalign` out 1: present only with `IF_ALIGN_CHECK_EN`.

## Operation
- **Registers:**
  - `pc`: next request address.
  - `out_pc`: address of the outstanding request.
  - `buf_valid`, `buf_inst`, `buf_pc`: hold buffer.
  - `state`.
- **FSM states:**
  - `IF_IDLE`: no request outstanding.
  - `IF_WAIT`: one request outstanding, response wanted.
  - `IF_DRAIN`: one request outstanding, response to be discarded.
- **Live response:** `imem_rsp_valid && state==IF_WAIT`.
- **Presentation priority:**
  1. If `buf_valid`, present the buffer.
  2. Else if there is a live response, present `imem_rsp_data` and `out_pc` combinationally (bypass).
  3. Else present `NOP_INST`, address `pc`, and raise `fetch_bubble`.
- **Consumption:** the presented valid word is consumed on any cycle with `stall==0`.
- **Capture:** a live response that is not consumed this cycle (because `stall`, or because the buffer is occupied) is written to the buffer. The buffer is never overwritten while valid. A request is not issued if that would be required.
- **Request issue:** `imem_req_valid` = !`redirect_valid` && (state==IF_IDLE || live response) && (buffer free at next edge) && state!=IF_DRAIN.
- **On acceptance (valid && ready):**
  - `out_pc` <= `pc`.
  - `pc` <= `pc`+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - Go to (or stay in) IF_WAIT.
- **Response without new acceptance:** IF_WAIT → IF_IDLE.
- **Redirect (highest priority, overrides stall):**
  - `pc` <= target with bits [1:0] cleared.
  - `buf_valid` <= 0.
  - Any same-cycle response is discarded and not presented.
  - No request is issued that cycle.
  - If a request is outstanding and its response has not arrived this cycle, go to IF_DRAIN; otherwise go to IF_IDLE.
- **IF_DRAIN:** on `imem_rsp_valid`, drop the response and go to IF_IDLE. A redirect in IF_DRAIN updates `pc` only and stays in IF_DRAIN.
- **Reset mid-transaction:** a response for a pre-reset request is not tracked. The imem side must be reset by the same `rst_n`.

## Timing
- **Reset values:**
  - `pc`=`RESET_PC`, state=IF_IDLE, `buf_valid`=0, `out_pc`=0.
  - `imem_req_valid`=0 while reset is asserted.
  - `instruction_next`=`NOP_INST`, `inst_address_next`=`RESET_PC`, `fetch_bubble`=1.
- **First request:** `imem_req_valid`=1 in the first cycle after reset deassertion.
- **Latency:** request accepted in cycle N, response in N+1 → word on `instruction_next` in N+1, captured by IF/ID at the end of N+1.
- **Throughput:** 1 instruction/cycle with a zero-wait imem and no stall.
- **Redirect in cycle R:** first request to the target in R+1 (from IF_IDLE), or one cycle after the drained response.
- **Stall:** outputs stable for every stalled cycle. No duplicate or lost instruction across stall release.

## Configuration
- **`IF_ALIGN_CHECK_EN` defined:**
  - `fetch_misalign` port exists, reset 0.
  - It is a registered one-cycle pulse in R+1 when a redirect in cycle R carries `redirect_target[1:0]`!=0.
  - Fetch continues at the target with bits [1:0] cleared.
- **`IF_ALIGN_CHECK_EN` undefined:** port absent; bits [1:0] are cleared silently.

## Structure
- **Package `if_pkg`:**
  - state enum `IF_IDLE`/`IF_WAIT`/`IF_DRAIN`.
  - `IF_NOP` constant.
  - `IF_PC_STEP`=4.
  - default `RESET_PC`.
- **Sub-module `if_hold_buf`:** one-entry hold buffer with load/consume/flush inputs and valid/inst/pc outputs. The top level holds the PC, FSM, and request logic.

## Test plan
- **Reset:** reset deasserts with `RESET_PC`=0x0, zero-wait imem → requests 0x0, 0x4, 0x8 in consecutive cycles; each word appears on `instruction_next` one cycle after its request; `fetch_bubble` is 1 only in the first cycle.
- **Stall:** `stall` high for 3 cycles while the word for 0x8 is presented → 0x8 held for 3 cycles; 0xC is presented the cycle after release; no duplicate.
- **Redirect with request in flight:** imem latency 3 cycles, redirect to 0x100 while a response for 0x10 is outstanding → 0x10 is never presented; next request is 0x100 after the drained response.
- **Simultaneous redirect and stall:** redirect to 0x200 while the buffer holds 0x14 → buffer flushed; bubble presented; 0x200 fetched next.
- **Wrap:** redirect to 0xFFFF_FFFC → next request address is 0x0000_0000.
- **Misaligned target:** `IF_ALIGN_CHECK_EN` defined, redirect to 0x102 → `fetch_misalign` pulses once; fetch address is 0x100.

Source files
------------

// File: rtl/if_pkg.sv
// ============================================================================
// Module : if_pkg
// Brief  : Shared types and constants for the instruction-fetch stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package if_pkg;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_WAIT  = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_e;

    localparam logic [31:0] IF_NOP      = 32'h0000_0000;
    localparam logic [31:0] IF_PC_STEP  = 32'd4;
    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] if_word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_stage_if.sv
// ============================================================================
// Module : if_fetch_stage_if
// Brief  : Instruction-memory request/response channel (fetch is master).
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface if_fetch_stage_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

`default_nettype wire

// File: rtl/if_hold_buf.sv
// ============================================================================
// Module : if_hold_buf
// Brief  : One-entry hold buffer for a fetched word and its address.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module if_hold_buf (
    input  wire         clk,
    input  wire         rst_n,
    input  wire         load_i,
    input  wire         consume_i,
    input  wire         flush_i,
    input  wire  [31:0] inst_i,
    input  wire  [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;

    // Flush beats load beats consume; a load with a same-cycle consume refills.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
        end else if (consume_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module : if_fetch_stage
// Brief  : MIPS IF stage: PC, imem request FSM, stall hold buffer, redirect
//          kill. Optional IF_ALIGN_CHECK_EN adds the fetch_misalign pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC,
    parameter logic [31:0] NOP_INST = IF_NOP
) (
    input  wire                     clk,
    input  wire                     rst_n,
    input  wire                     stall,
    input  wire                     redirect_valid,
    input  wire              [31:0] redirect_target,
    if_fetch_stage_if.master        imem,
    output logic             [31:0] instruction_next,
    output logic             [31:0] inst_address_next,
`ifdef IF_ALIGN_CHECK_EN
    output logic                    fetch_misalign,
`endif
    output logic                    fetch_bubble
);

    if_state_e   state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] out_pc_q;

    logic        buf_valid;
    logic [31:0] buf_inst;
    logic [31:0] buf_pc;
    logic        buf_load;
    logic        buf_consume;
    logic        buf_valid_d;

    logic        live_rsp;
    logic        req_fire;

    assign live_rsp = imem.imem_rsp_valid && (state_q == IF_WAIT);

    always_comb begin
        instruction_next  = NOP_INST;
        inst_address_next = pc_q;
        fetch_bubble      = 1'b1;
        if (buf_valid) begin
            instruction_next  = buf_inst;
            inst_address_next = buf_pc;
            fetch_bubble      = 1'b0;
        end else if (live_rsp && !redirect_valid) begin
            instruction_next  = imem.imem_rsp_data;
            inst_address_next = out_pc_q;
            fetch_bubble      = 1'b0;
        end
    end

    // A live word not taken by IF/ID this cycle (stall, or buffer ahead of it) is parked.
    always_comb begin
        buf_load    = live_rsp && !redirect_valid && (buf_valid || stall);
        buf_consume = buf_valid && !stall;
        buf_valid_d = buf_valid;
        if (redirect_valid) begin
            buf_valid_d = 1'b0;
        end else if (buf_load) begin
            buf_valid_d = 1'b1;
        end else if (buf_consume) begin
            buf_valid_d = 1'b0;
        end
    end

    // A new request is only issued if its response is guaranteed a free landing slot.
    always_comb begin
        imem.imem_req_valid = !rst_n && !redirect_valid && (state_q != IF_DRAIN)
                              && ((state_q == IF_IDLE) || live_rsp) && !buf_valid_d;
        imem.imem_req_addr  = pc_q;
    end

    assign req_fire = imem.imem_req_valid && imem.imem_req_ready;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = if_word_align(redirect_target);
        end else if (req_fire) begin
            pc_d = pc_q + IF_PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= IF_IDLE;
            pc_q     <= RESET_PC;
            out_pc_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (req_fire) begin
                out_pc_q <= pc_q;
            end
            case (state_q)
                IF_IDLE, IF_WAIT: begin
                    if (redirect_valid) begin
                        state_q <= (state_q == IF_WAIT && !imem.imem_rsp_valid) ? IF_DRAIN : IF_IDLE;
                    end else if (req_fire) begin
                        state_q <= IF_WAIT;
                    end else if (live_rsp) begin
                        state_q <= IF_IDLE;
                    end
                end
                // The killed response may coincide with another redirect; it still ends the drain.
                IF_DRAIN: begin
                    if (imem.imem_rsp_valid) begin
                        state_q <= IF_IDLE;
                    end
                end
                default: state_q <= IF_IDLE;
            endcase
        end
    end

    if_hold_buf u_hold_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (buf_load),
        .consume_i (buf_consume),
        .flush_i   (redirect_valid),
        .inst_i    (imem.imem_rsp_data),
        .pc_i      (out_pc_q),
        .valid_o   (buf_valid),
        .inst_o    (buf_inst),
        .pc_o      (buf_pc)
    );

`ifdef IF_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_valid && (redirect_target[1:0] != 2'b00);
        end
    end

    assign fetch_misalign = misalign_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// Module : tb_if_fetch_stage
// Brief  : Directed self-checking bench for if_fetch_stage with an in-order
//          variable-latency imem responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

    localparam logic [31:0] C_NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instruction_next;
    logic [31:0] inst_address_next;
    logic        fetch_bubble;
`ifdef IF_ALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 1;

    if_fetch_stage_if mif ();

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (C_NOP)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .imem              (mif),
        .instruction_next  (instruction_next),
        .inst_address_next (inst_address_next),
`ifdef IF_ALIGN_CHECK_EN
        .fetch_misalign    (fetch_misalign),
`endif
        .fetch_bubble      (fetch_bubble)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // In-order imem: a request accepted at the end of cycle N answers in cycle N+lat.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pend_q[$];
    int    cyc = 0;

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pend_q.delete();
            mif.imem_rsp_valid <= 1'b0;
            mif.imem_rsp_data  <= '0;
        end else begin
            if (mif.imem_rsp_valid && pend_q.size() > 0) begin
                pend_q.delete(0);
            end
            if (mif.imem_req_valid && mif.imem_req_ready) begin
                pend_q.push_back('{addr: mif.imem_req_addr, due: cyc + lat});
            end
            if (pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
                mif.imem_rsp_valid <= 1'b1;
                mif.imem_rsp_data  <= mem_word(pend_q[0].addr);
            end else begin
                mif.imem_rsp_valid <= 1'b0;
            end
            cyc = cyc + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic chk_present(input string tag, input logic [31:0] inst,
                               input logic [31:0] addr, input logic bub);
        check_val({tag, "_inst"}, instruction_next, inst);
        check_val({tag, "_addr"}, inst_address_next, addr);
        check_val({tag, "_bubble"}, 32'(fetch_bubble), 32'(bub));
    endtask

    task automatic chk_req(input string tag, input logic vld, input logic [31:0] addr);
        check_val({tag, "_req_valid"}, 32'(mif.imem_req_valid), 32'(vld));
        if (vld) begin
            check_val({tag, "_req_addr"}, mif.imem_req_addr, addr);
        end
    endtask

    initial begin
        rst_n               = 1'b1;
        stall               = 1'b0;
        redirect_valid      = 1'b0;
        redirect_target     = '0;
        mif.imem_req_ready  = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk_req("rst", 1'b0, 32'h0);
        chk_present("rst", C_NOP, 32'h0, 1'b1);
`ifdef IF_ALIGN_CHECK_EN
        check_val("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif

        // Reset release and back-to-back fetch
        @(negedge clk); rst_n = 1'b0; #1;
        chk_req("c0", 1'b1, 32'h0);
        chk_present("c0", C_NOP, 32'h0, 1'b1);
        @(negedge clk); #1;
        chk_present("c1", mem_word(32'h0), 32'h0, 1'b0);
        chk_req("c1", 1'b1, 32'h4);
        @(negedge clk); #1;
        chk_present("c2", mem_word(32'h4), 32'h4, 1'b0);
        chk_req("c2", 1'b1, 32'h8);

        // Three stalled cycles on 0x8
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); stall = 1'b1; #1;
            chk_present($sformatf("stall%0d", i), mem_word(32'h8), 32'h8, 1'b0);
            chk_req($sformatf("stall%0d", i), 1'b0, 32'h0);
        end
        @(negedge clk); stall = 1'b0; #1;
        chk_present("release", mem_word(32'h8), 32'h8, 1'b0);
        chk_req("release", 1'b1, 32'hC);
        @(negedge clk); lat = 3; #1;
        chk_present("c7", mem_word(32'hC), 32'hC, 1'b0);
        chk_req("c7", 1'b1, 32'h10);

        // Redirect with 0x10 in flight
        @(negedge clk); redirect_valid = 1'b1; redirect_target = 32'h100; #1;
        chk_present("c8", C_NOP, 32'h14, 1'b1);
        chk_req("c8", 1'b0, 32'h0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk_present("drain0", C_NOP, 32'h100, 1'b1);
        chk_req("drain0", 1'b0, 32'h0);
        @(negedge clk); #1;
        chk_present("drain1", C_NOP, 32'h100, 1'b1);
        chk_req("drain1", 1'b0, 32'h0);
        @(negedge clk); lat = 1; #1;
        chk_present("c11", C_NOP, 32'h100, 1'b1);
        chk_req("c11", 1'b1, 32'h100);

        // Redirect coinciding with a live response kills it
        @(negedge clk); redirect_valid = 1'b1; redirect_target = 32'h14; #1;
        chk_present("c12", C_NOP, 32'h104, 1'b1);
        chk_req("c12", 1'b0, 32'h0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk_present("c13", C_NOP, 32'h14, 1'b1);
        chk_req("c13", 1'b1, 32'h14);

        // Buffer holds 0x14, then redirect under stall flushes it
        @(negedge clk); stall = 1'b1; #1;
        chk_present("c14", mem_word(32'h14), 32'h14, 1'b0);
        chk_req("c14", 1'b0, 32'h0);
        @(negedge clk); redirect_valid = 1'b1; redirect_target = 32'h200; #1;
        chk_present("c15", mem_word(32'h14), 32'h14, 1'b0);
        chk_req("c15", 1'b0, 32'h0);
        @(negedge clk); redirect_valid = 1'b0; stall = 1'b0; #1;
        chk_present("flushed", C_NOP, 32'h200, 1'b1);
        chk_req("flushed", 1'b1, 32'h200);

        // Wrap at the top of the address space
        @(negedge clk); redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC; #1;
        chk_present("c17", C_NOP, 32'h204, 1'b1);
        chk_req("c17", 1'b0, 32'h0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk_present("c18", C_NOP, 32'hFFFF_FFFC, 1'b1);
        chk_req("c18", 1'b1, 32'hFFFF_FFFC);
`ifdef IF_ALIGN_CHECK_EN
        check_val("aligned_no_pulse", 32'(fetch_misalign), 32'd0);
`endif
        @(negedge clk); #1;
        chk_present("wrap", mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1'b0);
        chk_req("wrap", 1'b1, 32'h0);

        // Misaligned target is word-aligned
        @(negedge clk); redirect_valid = 1'b1; redirect_target = 32'h102; #1;
        chk_present("c20", C_NOP, 32'h4, 1'b1);
        chk_req("c20", 1'b0, 32'h0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk_present("c21", C_NOP, 32'h100, 1'b1);
        chk_req("c21", 1'b1, 32'h100);
`ifdef IF_ALIGN_CHECK_EN
        check_val("misalign_pulse", 32'(fetch_misalign), 32'd1);
`endif
        @(negedge clk); #1;
        chk_present("c22", mem_word(32'h100), 32'h100, 1'b0);
        chk_req("c22", 1'b1, 32'h104);
`ifdef IF_ALIGN_CHECK_EN
        check_val("misalign_clear", 32'(fetch_misalign), 32'd0);
`endif
        @(negedge clk); #1;
        chk_present("c23", mem_word(32'h104), 32'h104, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
